// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
// Shared constants and the controller state type for the Montgomery
// multiplier controller (mont_mul_ctrl) and its shared multiplier unit.
//   WORD_W       operand / modulus width
//   PROD_W       full product width
//   MUL_LAT      cycles from the mul_start cycle to the mul_done cycle
//   FLUSH_CYCLES cycles spent in FLUSH after reset (> MUL_LAT so any
//                in-flight product drains before new work starts)
// -----------------------------------------------------------------------------
package mont_pkg;

    localparam int WORD_W       = 64;
    localparam int PROD_W       = 128;
    localparam int MUL_LAT      = 33;
    localparam int FLUSH_CYCLES = 34;

    typedef enum logic [3:0] {
        FLUSH,
        IDLE,
        MUL_T,
        WAIT_T,
        MUL_M,
        WAIT_M,
        MUL_MN,
        WAIT_MN,
        REDUCE,
        RESP
    } state_t;

endpackage

// File: rtl/mont_mul_ctrl_multiplier.sv
// -----------------------------------------------------------------------------
// mont_mul_ctrl_multiplier
// Shared 64x64 unsigned radix-4 multiplier. Two bits of B are consumed per
// cycle, so a product takes 32 accumulate steps after the start edge; done
// pulses for one cycle MUL_LAT cycles after the start cycle, with R valid
// from then until the next product completes. The unit has no reset: a
// product in flight when the controller resets simply runs to completion.
//   clk    clock
//   start  one-cycle pulse, samples A and B (restarts any product in flight)
//   A, B   operands
//   R      128-bit product
//   done   one-cycle completion pulse
// -----------------------------------------------------------------------------
module mont_mul_ctrl_multiplier
    import mont_pkg::*;
(
    input  logic              clk,
    input  logic              start,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    output logic [PROD_W-1:0] R,
    output logic              done
);

    // Step counter preload: MUL_LAT-1 steps total, counting down to zero.
    localparam logic [4:0] CNT_INIT = 5'(MUL_LAT - 2);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] a_sh;
    logic [WORD_W-1:0] b_sh;
    logic [4:0]        cnt;
    logic              busy;
    logic [PROD_W-1:0] pp;

    // Partial product for the current radix-4 digit of B.
    always_comb begin
        case (b_sh[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = a_sh;
            2'd2:    pp = a_sh << 1;
            default: pp = a_sh + (a_sh << 1);
        endcase
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (start) begin
            acc  <= '0;
            a_sh <= {{(PROD_W-WORD_W){1'b0}}, A};
            b_sh <= B;
            cnt  <= CNT_INIT;
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= acc + pp;
            a_sh <= a_sh << 2;
            b_sh <= b_sh >> 2;
            cnt  <= cnt - 5'd1;
            if (cnt == 5'd0) begin
                busy <= 1'b0;
                done <= 1'b1;
                R    <= acc + pp;
            end
        end
    end

endmodule

// File: rtl/mont_mul_ctrl.sv
// -----------------------------------------------------------------------------
// mont_mul_ctrl
// Montgomery multiplication controller: resp_r = a*b*2^-64 mod N, computed
// with three passes through one shared multiplier (T=a*b, m=T*N', s=T+m*N)
// followed by a single conditional subtract.
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_we, cfg_n, cfg_n_prime modulus N (odd) and N' = -N^-1 mod 2^64;
//                              loaded only in IDLE or FLUSH
//   req_valid/req_ready        operand handshake, req_a/req_b < N
//   resp_valid/resp_ready      result handshake, resp_r held until consumed
// -----------------------------------------------------------------------------
module mont_mul_ctrl
    import mont_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [WORD_W-1:0] cfg_n,
    input  logic [WORD_W-1:0] cfg_n_prime,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_a,
    input  logic [WORD_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_r
);

    localparam logic [5:0] FLUSH_LAST = 6'(FLUSH_CYCLES - 1);

    state_t              state, state_nx;
    logic [5:0]          flush_cnt;
    logic [WORD_W-1:0]   n_q, np_q;
    logic [WORD_W-1:0]   a_q, b_q, m_q;
    logic [PROD_W-1:0]   t_q;
    logic [PROD_W:0]     s_q;

    logic                mul_start;
    logic [WORD_W-1:0]   mul_a, mul_b;
    logic [PROD_W-1:0]   mul_r;
    logic                mul_done;

    logic                cfg_open;
    logic [WORD_W:0]     t_hi;
    logic [WORD_W-1:0]   t_red;

    assign cfg_open = (state == FLUSH) || (state == IDLE);

    // t < 2N, so the subtract result always fits in WORD_W bits.
    assign t_hi  = s_q[PROD_W:WORD_W];
    assign t_red = (t_hi >= {1'b0, n_q}) ? (t_hi[WORD_W-1:0] - n_q)
                                         : t_hi[WORD_W-1:0];

    mont_mul_ctrl_multiplier u_mul (
        .clk   (clk),
        .start (mul_start),
        .A     (mul_a),
        .B     (mul_b),
        .R     (mul_r),
        .done  (mul_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 6'd1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q    <= '0;
            np_q   <= '0;
            resp_r <= '0;
        end else begin
            if (cfg_we && cfg_open) begin
                n_q  <= cfg_n;
                np_q <= cfg_n_prime;
            end
            if (state == REDUCE)
                resp_r <= t_red;
        end
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            a_q <= req_a;
            b_q <= req_b;
        end
        if (state == WAIT_T && mul_done)
            t_q <= mul_r;
        if (state == WAIT_M && mul_done)
            m_q <= mul_r[WORD_W-1:0];
        if (state == WAIT_MN && mul_done)
            s_q <= {1'b0, t_q} + {1'b0, mul_r};
    end

    // mul_done is only looked at in WAIT_* states, so a late pulse from a
    // product abandoned by reset falls harmlessly into FLUSH.
    always_comb begin
        state_nx   = state;
        mul_start  = 1'b0;
        mul_a      = a_q;
        mul_b      = b_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_nx = IDLE;
            IDLE: begin
                req_ready = !cfg_we;
                if (req_valid && !cfg_we) state_nx = MUL_T;
            end
            MUL_T: begin
                mul_start = 1'b1;
                state_nx  = WAIT_T;
            end
            WAIT_T:  if (mul_done) state_nx = MUL_M;
            MUL_M: begin
                mul_start = 1'b1;
                mul_a     = t_q[WORD_W-1:0];
                mul_b     = np_q;
                state_nx  = WAIT_M;
            end
            WAIT_M:  if (mul_done) state_nx = MUL_MN;
            MUL_MN: begin
                mul_start = 1'b1;
                mul_a     = m_q;
                mul_b     = n_q;
                state_nx  = WAIT_MN;
            end
            WAIT_MN: if (mul_done) state_nx = REDUCE;
            REDUCE:  state_nx = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = FLUSH;
        endcase
    end

    // With a consistent N/N' pair the low word of s is zero by construction.
    a_redc_low_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == REDUCE) |-> (s_q[WORD_W-1:0] == '0));

endmodule
